// File: rtl/reg_16.sv
// General-purpose storage word of the vector datapath: loads I on a rising CLK
// edge when Write is high, otherwise recirculates its contents.
module reg_16 #(
  parameter int unsigned          WIDTH       = 16,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             Write,
  output logic [WIDTH-1:0] O
);

  logic [WIDTH-1:0] d_c;

  // Per-bit 2:1 mux: new data on Write, otherwise feed the stored bit back.
  always_comb begin
    d_c = O;
    if (Write) begin
      d_c = I;
    end
  end

  // Storage flops; reset clears the word without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O <= RESET_VALUE;
    end else begin
      O <= d_c;
    end
  end

endmodule

// File: tb/tb_reg_16.sv
// Self-checking bench for reg_16: directed plan followed by randomized writes,
// holds and mid-cycle resets compared against a behavioural model.
module tb_reg_16;

  localparam int unsigned W = 16;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] I;
  logic         Write;
  logic [W-1:0] O;

  logic [W-1:0] model;
  int           n_checks;
  int           n_errors;

  reg_16 #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .I    (I),
    .Write(Write),
    .O    (O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] exp);
    n_checks++;
    assert (O === exp)
    else begin
      n_errors++;
      $error("FAIL %s: O=%h expected=%h", tag, O, exp);
    end
  endtask

  // Drive at the falling edge, sample just after the rising edge.
  task automatic cycle(input string tag, input logic w, input logic [W-1:0] d);
    @(negedge CLK);
    Write = w;
    I     = d;
    @(posedge CLK);
    #1;
    if (w) model = d;
    chk(tag, model);
  endtask

  task automatic mid_reset(input string tag);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    model = '0;
    chk(tag, model);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model    = '0;
    RST_N    = 1'b1;
    I        = 16'hFFFF;
    Write    = 1'b1;

    // Reset held across edges with Write=1 and I=FFFF.
    #2;
    RST_N = 1'b0;
    #1;
    chk("reset_async", 16'h0000);
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      #1;
      chk("reset_hold", 16'h0000);
    end
    @(negedge CLK);
    Write = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("reset_release", 16'h0000);

    // Write then hold.
    cycle("write_ffff", 1'b1, 16'hFFFF);
    cycle("hold_ffff", 1'b0, 16'h0000);

    // Alternating pattern.
    for (int r = 0; r < 3; r++) begin
      cycle("write_5555", 1'b1, 16'h5555);
      cycle("hold_5555", 1'b0, 16'h5555);
      cycle("write_ffff_alt", 1'b1, 16'hFFFF);
      cycle("hold_ffff_alt", 1'b0, 16'h1111);
    end
    cycle("write_5555_final", 1'b1, 16'h5555);

    // Input changes ignored while Write is low.
    cycle("ignore_aaaa", 1'b0, 16'hAAAA);
    cycle("ignore_0000", 1'b0, 16'h0000);
    cycle("ignore_aaaa2", 1'b0, 16'hAAAA);
    @(negedge CLK);
    chk("ignore_midcycle", 16'h5555);

    // Asynchronous reset between edges, then a normal write.
    cycle("pre_reset_ffff", 1'b1, 16'hFFFF);
    Write = 1'b0;
    mid_reset("reset_midcycle");
    @(posedge CLK);
    #1;
    chk("post_reset_hold", model);
    cycle("write_1234", 1'b1, 16'h1234);

    // Back-to-back writes.
    cycle("b2b_0001", 1'b1, 16'h0001);
    cycle("b2b_8000", 1'b1, 16'h8000);
    cycle("b2b_7ffe", 1'b1, 16'h7FFE);
    cycle("b2b_hold", 1'b0, 16'hBEEF);

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        @(negedge CLK);
        Write = 1'b1;
        I     = 16'($urandom);
        mid_reset("rand_reset");
        @(posedge CLK);
        #1;
        model = I;
        chk("rand_after_reset", model);
      end else begin
        cycle("rand_cycle", 1'($urandom_range(0, 1)), 16'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
